// File: rtl/fb_avl_burst_ctrl.sv
// fb_avl_burst_ctrl: Avalon-MM burst master that writes camera frames into one DDR framebuffer and reads them back.
// Define FB_AVL_TEST_PATTERN_EN to write the frame word offset as data instead of wr_data (DDR bring-up).
module fb_avl_burst_ctrl #(
    parameter int ADDR_WIDTH  = 26,
    parameter int DATA_WIDTH  = 32,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_WORDS = 307200,
    parameter int BURST_LEN   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  avl_ready,
    output logic                  full,
    output logic                  rd_done,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    output logic [ADDR_WIDTH-1:0] avl_address,
    output logic                  avl_write,
    output logic                  avl_read,
    output logic [DATA_WIDTH-1:0] avl_writedata,
    output logic [6:0]            avl_burstcount,
    input  logic                  avl_waitrequest,
    input  logic [DATA_WIDTH-1:0] avl_readdata,
    input  logic                  avl_readdatavalid
);

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_CMD,
        RD_WAIT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] FRAME_END = ADDR_WIDTH'(FRAME_WORDS);
    localparam logic [6:0]            LAST_BEAT = 7'(BURST_LEN - 1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [6:0]            beat_cnt;
    logic [6:0]            rx_cnt;
    logic                  beat_accept;
    logic                  rx_beat;
    logic                  wr_wrap;
    logic                  rd_wrap;

    // Handshakes are decoded straight from state so the FSM block never reads its own outputs.
    assign beat_accept    = (state == WR_BURST) && !wr_en && !avl_waitrequest;
    assign rx_beat        = (state == RD_WAIT) && avl_readdatavalid;
    assign wr_wrap        = (wr_ptr + STEP) == FRAME_END;
    assign rd_wrap        = (rd_ptr + STEP) == FRAME_END;
    assign avl_ready      = ~avl_waitrequest;
    assign avl_burstcount = 7'(BURST_LEN);

`ifdef FB_AVL_TEST_PATTERN_EN
    logic [ADDR_WIDTH-1:0] pattern_word;
    logic                  unused_wr_data;

    assign pattern_word   = wr_ptr + ADDR_WIDTH'(beat_cnt);
    assign avl_writedata  = DATA_WIDTH'(pattern_word);
    assign unused_wr_data = ^wr_data;
`else
    assign avl_writedata  = wr_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The burst address stays at its start word for every beat; IDLE parks on the next write burst.
    always_comb begin
        state_next  = state;
        avl_write   = 1'b0;
        avl_read    = 1'b0;
        avl_address = BASE + wr_ptr;
        case (state)
            IDLE: begin
                if (!wr_en) begin
                    state_next = WR_BURST;
                end else if (!rd_en) begin
                    state_next = RD_CMD;
                end
            end
            WR_BURST: begin
                avl_write = ~wr_en;
                if (beat_accept && (beat_cnt == LAST_BEAT)) begin
                    state_next = IDLE;
                end
            end
            RD_CMD: begin
                avl_read    = 1'b1;
                avl_address = BASE + rd_ptr;
                if (!avl_waitrequest) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                avl_address = BASE + rd_ptr;
                if (rx_beat && (rx_cnt == LAST_BEAT)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            beat_cnt      <= '0;
            rx_cnt        <= '0;
            full          <= 1'b0;
            rd_done       <= 1'b0;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
        end else begin
            full          <= 1'b0;
            rd_done       <= 1'b0;
            rd_data_valid <= 1'b0;

            if (beat_accept) begin
                if (beat_cnt == LAST_BEAT) begin
                    beat_cnt <= '0;
                    wr_ptr   <= wr_wrap ? '0 : wr_ptr + STEP;
                    full     <= wr_wrap;
                end else begin
                    beat_cnt <= beat_cnt + 7'd1;
                end
            end

            // Beats arriving outside RD_WAIT (e.g. after a mid-burst reset) are deliberately dropped.
            if (rx_beat) begin
                rd_data       <= avl_readdata;
                rd_data_valid <= 1'b1;
                if (rx_cnt == LAST_BEAT) begin
                    rx_cnt  <= '0;
                    rd_ptr  <= rd_wrap ? '0 : rd_ptr + STEP;
                    rd_done <= rd_wrap;
                end else begin
                    rx_cnt <= rx_cnt + 7'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_avl_burst_ctrl.sv
// tb_fb_avl_burst_ctrl: randomized bench with an Avalon slave memory, a frame-level reference model and a scoreboard monitor.
module tb_fb_avl_burst_ctrl;

    localparam int AW   = 26;
    localparam int DW   = 32;
    localparam int BASE = 32'h100;
    localparam int FW   = 16;
    localparam int BL   = 8;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] wr_data;
    logic          avl_ready;
    logic          full;
    logic          rd_done;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;
    logic [AW-1:0] avl_address;
    logic          avl_write;
    logic          avl_read;
    logic [DW-1:0] avl_writedata;
    logic [6:0]    avl_burstcount;
    logic          avl_waitrequest;
    logic [DW-1:0] avl_readdata;
    logic          avl_readdatavalid;

    fb_avl_burst_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BASE_ADDR  (BASE),
        .FRAME_WORDS(FW),
        .BURST_LEN  (BL)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .wr_en            (wr_en),
        .rd_en            (rd_en),
        .wr_data          (wr_data),
        .avl_ready        (avl_ready),
        .full             (full),
        .rd_done          (rd_done),
        .rd_data          (rd_data),
        .rd_data_valid    (rd_data_valid),
        .avl_address      (avl_address),
        .avl_write        (avl_write),
        .avl_read         (avl_read),
        .avl_writedata    (avl_writedata),
        .avl_burstcount   (avl_burstcount),
        .avl_waitrequest  (avl_waitrequest),
        .avl_readdata     (avl_readdata),
        .avl_readdatavalid(avl_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            last;
    } wr_exp_t;

    typedef struct {
        logic [DW-1:0] data;
        bit            done;
    } rd_exp_t;

    wr_exp_t       exp_wr_q[$];
    rd_exp_t       exp_rd_q[$];
    logic [AW-1:0] exp_rdcmd_q[$];

    int            n_cmp = 0;
    int            n_fail = 0;
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    logic [DW-1:0] frame_model[FW];
    int            rd_cmds_seen = 0;
    int            rd_valids_seen = 0;
    bit            mon_en = 0;
    bit            drop_reads = 0;
    bit            full_due = 0;
    bit            rd_due = 0;

    logic [DW-1:0] mem[int];
    int            s_rremain = 0;
    int            s_ridx = 0;
    int            s_rdelay = 0;
    int            s_wbeat = 0;
    bit            s_cmd_pending = 0;
    logic [AW-1:0] s_rbase = '0;
    logic [AW-1:0] s_wbase = '0;
    logic [AW-1:0] s_cmd_addr = '0;

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: wait bound expired (t=%0t)", name, $time);
        finish_run();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_avl_write"}, avl_write, 0);
        check({tag, "_avl_read"}, avl_read, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_rd_done"}, rd_done, 0);
        check({tag, "_rd_data_valid"}, rd_data_valid, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_avl_address"}, avl_address, BASE);
        check({tag, "_burstcount"}, avl_burstcount, BL);
    endtask

    // Reference model: frame offset decides burst address, data and end-of-frame flags.
    function automatic void push_write(input logic [DW-1:0] word);
        wr_exp_t e;
        int      pos;
        pos = wr_cnt % FW;
`ifdef FB_AVL_TEST_PATTERN_EN
        e.data = DW'(pos);
`else
        e.data = word;
`endif
        e.addr = AW'(BASE + pos - (pos % BL));
        e.last = (pos == FW - 1);
        frame_model[pos] = e.data;
        exp_wr_q.push_back(e);
        wr_cnt++;
    endfunction

    function automatic void push_read_burst();
        rd_exp_t e;
        int      pos;
        pos = rd_cnt % FW;
        exp_rdcmd_q.push_back(AW'(BASE + pos));
        for (int k = 0; k < BL; k++) begin
            e.data = frame_model[pos + k];
            e.done = (pos + k == FW - 1);
            exp_rd_q.push_back(e);
        end
        rd_cnt += BL;
    endfunction

    // Controller side of the show-ahead FIFO: the word advances only on an accepted beat.
    task automatic write_words(input int n, input bit gaps);
        logic [DW-1:0] word;
        bit            accepted;
        int            budget;
        for (int i = 0; i < n; i++) begin
            word = $urandom;
            push_write(word);
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                wr_en = 1'b1;
                @(posedge clk);
                #1;
            end
            wr_en    = 1'b0;
            wr_data  = word;
            accepted = 0;
            budget   = 0;
            while (!accepted) begin
                @(negedge clk);
                accepted = avl_write && !avl_waitrequest;
                @(posedge clk);
                #1;
                budget++;
                if (!accepted && budget > 100) timeout("wr_beat_wait");
            end
        end
        wr_en   = 1'b1;
        wr_data = $urandom;
    endtask

    task automatic wait_read_burst(input int cmd_start, input int val_target);
        int budget;
        budget = 0;
        while (rd_cmds_seen <= cmd_start) begin
            @(negedge clk);
            #1;
            budget++;
            if (budget > 200) timeout("rd_cmd_wait");
        end
        @(posedge clk);
        #1;
        rd_en  = 1'b1;
        budget = 0;
        while (rd_valids_seen < val_target) begin
            @(negedge clk);
            #1;
            budget++;
            if (budget > 300) timeout("rd_data_wait");
        end
    endtask

    task automatic read_bursts(input int nb);
        int c;
        int v;
        for (int b = 0; b < nb; b++) begin
            c = rd_cmds_seen;
            v = rd_valids_seen;
            push_read_burst();
            rd_en = 1'b0;
            wait_read_burst(c, v + BL);
        end
    endtask

    // Avalon slave: random waitrequest, random read latency and gaps, backed by a sparse memory.
    initial begin
        avl_waitrequest   = 1'b1;
        avl_readdatavalid = 1'b0;
        avl_readdata      = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                s_wbeat = 0;
            end else if (avl_write && !avl_waitrequest) begin
                if (s_wbeat == 0) s_wbase = avl_address;
                mem[int'(s_wbase) + s_wbeat] = avl_writedata;
                s_wbeat = (s_wbeat + 1) % BL;
            end
            if (avl_read && !avl_waitrequest) begin
                s_cmd_pending = 1;
                s_cmd_addr    = avl_address;
            end
            @(posedge clk);
            #1;
            avl_waitrequest = ($urandom_range(0, 9) < 3);
            if (s_cmd_pending) begin
                s_cmd_pending = 0;
                s_rbase       = s_cmd_addr;
                s_ridx        = 0;
                s_rremain     = BL;
                s_rdelay      = $urandom_range(1, 5);
            end
            if (s_rremain > 0 && s_rdelay == 0 && $urandom_range(0, 4) != 0) begin
                avl_readdatavalid = 1'b1;
                avl_readdata      = mem.exists(int'(s_rbase) + s_ridx) ? mem[int'(s_rbase) + s_ridx] : '0;
                s_ridx++;
                s_rremain--;
            end else begin
                if (s_rremain > 0 && s_rdelay > 0) s_rdelay--;
                avl_readdatavalid = 1'b0;
                avl_readdata      = $urandom;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a write beat, read command or read word.
    initial begin
        wr_exp_t       we;
        rd_exp_t       re;
        logic [AW-1:0] ca;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("avl_ready", avl_ready, !avl_waitrequest);
                if (full || full_due) check("full_pulse", full, full_due);
                full_due = 0;
                if (rd_data_valid || rd_due) check("rd_valid_latency", rd_data_valid, rd_due);
                if (rd_data_valid) begin
                    rd_valids_seen++;
                    if (exp_rd_q.size() == 0) begin
                        check("rd_unexpected_valid", 1, 0);
                    end else begin
                        re = exp_rd_q.pop_front();
                        check("rd_data", rd_data, re.data);
                        check("rd_done", rd_done, re.done);
                    end
                end else if (rd_done) begin
                    check("rd_done_without_valid", rd_done, 0);
                end
                rd_due = avl_readdatavalid && !drop_reads;
                if (avl_write && !avl_waitrequest) begin
                    if (exp_wr_q.size() == 0) begin
                        check("wr_unexpected_beat", 1, 0);
                    end else begin
                        we = exp_wr_q.pop_front();
                        check("wr_address", avl_address, we.addr);
                        check("wr_data", avl_writedata, we.data);
                        check("wr_burstcount", avl_burstcount, BL);
                        full_due = we.last;
                    end
                end
                if (avl_read) begin
                    check("rd_cmd_not_write", avl_write, 0);
                    check("rd_one_outstanding", s_rremain, 0);
                    if (!avl_waitrequest) begin
                        rd_cmds_seen++;
                        if (exp_rdcmd_q.size() == 0) begin
                            check("rd_unexpected_cmd", 1, 0);
                        end else begin
                            ca = exp_rdcmd_q.pop_front();
                            check("rd_cmd_address", avl_address, ca);
                            check("rd_burstcount", avl_burstcount, BL);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        timeout("watchdog");
    end

    initial begin
        int c;
        int v;
        int budget;
        reset   = 1'b1;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = '0;
        for (int i = 0; i < FW; i++) frame_model[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        repeat (4) begin
            @(negedge clk);
            check("reset_avl_ready", avl_ready, !avl_waitrequest);
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1;

        $display("[TB] two frames written, then read back");
        write_words(2 * FW, 1);
        read_bursts(2 * FW / BL);

        $display("[TB] simultaneous write and read request");
        rd_en = 1'b0;
        write_words(BL, 0);
        c = rd_cmds_seen;
        v = rd_valids_seen;
        push_read_burst();
        @(negedge clk);
        check("s5_idle_after_write", avl_read, 0);
        @(negedge clk);
        check("s5_rd_cmd_next", avl_read, 1);
        #1;
        wait_read_burst(c, v + BL);

        $display("[TB] random mix of bursts");
        repeat (8) begin
            if ($urandom_range(0, 1) == 0) write_words(BL * $urandom_range(1, 2), 1);
            else read_bursts(1);
        end

        $display("[TB] reset during RD_WAIT");
        c = rd_cmds_seen;
        v = rd_valids_seen;
        push_read_burst();
        rd_en  = 1'b0;
        budget = 0;
        while (rd_cmds_seen <= c) begin
            @(negedge clk);
            #1;
            budget++;
            if (budget > 200) timeout("s6_cmd_wait");
        end
        @(posedge clk);
        #1;
        rd_en  = 1'b1;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
            if (budget > 200) timeout("s6_beat3_wait");
        end while (!(avl_readdatavalid && s_ridx == 3));
        @(posedge clk);
        #1;
        reset      = 1'b1;
        drop_reads = 1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_rd_q.delete();
        wr_cnt   = 0;
        rd_cnt   = 0;
        full_due = 0;
        check("s6_beats_before_reset", rd_valids_seen - v, 3);
        @(negedge clk);
        check_reset_outputs("s6");
        budget = 0;
        while (s_rremain > 0) begin
            @(negedge clk);
            budget++;
            if (budget > 200) timeout("s6_drain_wait");
        end
        repeat (2) @(negedge clk);
        check("s6_rd_data_after_drain", rd_data, 0);
        check("s6_no_valid_after_drain", rd_valids_seen - v, 3);
        @(posedge clk);
        #1;
        drop_reads = 0;

        $display("[TB] frame after reset restarts at base address");
        write_words(FW, 1);
        read_bursts(FW / BL);

        repeat (5) @(negedge clk);
        check("wr_queue_drained", exp_wr_q.size(), 0);
        check("rd_queue_drained", exp_rd_q.size(), 0);
        check("rd_cmd_queue_drained", exp_rdcmd_q.size(), 0);
        finish_run();
    end

endmodule
